// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the sequential multiword adder.
//   state_t            : controller states (IDLE, ADD, DONE)
//   DEF_SLICE_W        : default width of one adder slice
//   DEF_NUM_SLICES     : default number of slices per operand
package multiword_adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_SLICE_W    = 3;
    localparam int unsigned DEF_NUM_SLICES = 4;

endpackage

// File: rtl/ripple_carry_adder_beh.sv
// Combinational SLICE_W-bit adder, behavioural form.
//   A, B  : SLICE_W-bit addends
//   CIN   : carry in
//   SUM   : SLICE_W-bit sum
//   COUT  : carry out of the slice
module ripple_carry_adder_beh #(
    parameter int unsigned SLICE_W = 3
) (
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               CIN,
    output logic [SLICE_W-1:0] SUM,
    output logic               COUT
);

    always_comb begin
        {COUT, SUM} = {1'b0, A} + {1'b0, B} + {{SLICE_W{1'b0}}, CIN};
    end

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential multiword adder: adds two WORD_W operands one SLICE_W slice per
// cycle through a single shared slice adder, least-significant slice first.
//   CLK, RST             : clock, synchronous active-high reset
//   IN_VALID / IN_READY  : operand handshake (ready only in IDLE)
//   A, B, CIN            : operands and carry in, latched on acceptance
//   OUT_VALID / OUT_READY: result handshake; result held in DONE until taken
//   SUM, COUT            : registered result
//   BUSY                 : high while an operation is in ADD or DONE
module multiword_adder_seq
    import multiword_adder_seq_pkg::*;
#(
    parameter int unsigned SLICE_W    = DEF_SLICE_W,
    parameter int unsigned NUM_SLICES = DEF_NUM_SLICES,
    parameter int unsigned WORD_W     = SLICE_W * NUM_SLICES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              CIN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WORD_W-1:0] SUM,
    output logic              COUT,
    output logic              BUSY
);

    localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WORD_W-1:0]  a_q;
    logic [WORD_W-1:0]  b_q;
    logic [WORD_W-1:0]  sum_q;
    logic               cout_q;
    logic               out_valid_q;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Single shared slice adder, steered by the current slice index.
    ripple_carry_adder_beh #(
        .SLICE_W (SLICE_W)
    ) u_slice_adder (
        .A    (a_q[idx_q*SLICE_W +: SLICE_W]),
        .B    (b_q[idx_q*SLICE_W +: SLICE_W]),
        .CIN  (carry_q),
        .SUM  (slice_sum),
        .COUT (slice_cout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= CIN;
                        idx_q   <= '0;
                        // Clear so unwritten slices read as zero during ADD.
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign OUT_VALID = out_valid_q;
    assign SUM       = sum_q;
    assign COUT      = cout_q;

endmodule

// File: doc/multiword_adder_seq.md
MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

Interface
REQ-001 SHALL have parameter SLICE_W, default 3, giving the width of one adder slice.
REQ-002 SHALL have parameter NUM_SLICES, default 4, giving slices per operand; WORD_W = SLICE_W*NUM_SLICES (default 12).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 IN_VALID  input  1  operands A, B and CIN are valid.
REQ-007 IN_READY  output  1  block accepts operands this cycle.
REQ-008 A  input  WORD_W  operand A.
REQ-009 B  input  WORD_W  operand B.
REQ-010 CIN  input  1  carry in.
REQ-011 OUT_VALID  output  1  SUM and COUT are valid.
REQ-012 OUT_READY  input  1  consumer accepts the result.
REQ-013 SUM  output  WORD_W  registered sum.
REQ-014 COUT  output  1  registered carry out of the top slice.
REQ-015 BUSY  output  1  high in ADD or DONE.

Function
REQ-016 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-017 IN_READY SHALL be 1 only in IDLE.
REQ-018 IDLE with IN_VALID=1 SHALL latch A, B and CIN, clear the slice index and move to ADD on the same edge.
REQ-019 Each ADD cycle SHALL add slice[idx] of A and B plus the carry register, write the SLICE_W result into SUM slice[idx], store the carry-out and increment idx, least-significant slice first.
REQ-020 After the slice with idx=NUM_SLICES-1 the FSM SHALL enter DONE, set COUT to the final carry and assert OUT_VALID.
REQ-021 Latency SHALL be NUM_SLICES cycles: operands accepted at edge 0 give OUT_VALID=1 after edge NUM_SLICES (edge 4 by default).
REQ-022 In DONE, SUM, COUT and OUT_VALID SHALL hold stable until OUT_READY=1; that edge SHALL clear OUT_VALID and return to IDLE.
REQ-023 IN_VALID during ADD or DONE SHALL be ignored and SHALL NOT corrupt latched operands.
REQ-024 Arithmetic SHALL be modulo 2^WORD_W; {COUT,SUM} SHALL equal A+B+CIN exactly, including the all-ones wrap.
REQ-025 SUM SHALL be undefined-free, with zeroed bits not yet written while in ADD, and SHALL be valid only when OUT_VALID=1.

Reset
REQ-026 RST=1 SHALL force state IDLE, idx=0, carry=0, SUM=0, COUT=0, OUT_VALID=0 and BUSY=0 at the next edge; IN_READY SHALL be 1 in the cycle after reset.
REQ-027 Reset SHALL take priority over every other input, including mid-ADD and in DONE, and the in-flight operation SHALL be discarded with no output.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, ADD, DONE) and the default SLICE_W and NUM_SLICES constants.
REQ-029 One sub-module instance SHALL be used: ripple_carry_adder_beh (ports A, B, CIN, SUM, COUT, SLICE_W wide), combinational, fed from the latched operand slices.
REQ-030 Slice selection SHALL use an indexed part-select on idx; no per-slice duplicated adders.

Verification
REQ-031 A=0, B=0, CIN=0 -> SUM=12'h000, COUT=0, OUT_VALID after 4 cycles.
REQ-032 A=12'h007, B=12'h003, CIN=0 -> SUM=12'h00A, COUT=0 (carry crosses slice 0 into slice 1).
REQ-033 A=12'hFFF, B=12'h001, CIN=0 -> SUM=12'h000, COUT=1; also A=12'hFFF, B=0, CIN=1 -> same result.
REQ-034 A=12'h002, B=12'h001, OUT_READY held 0 for 3 cycles after OUT_VALID -> SUM=12'h003 stable, BUSY=1 and IN_READY=0 throughout; a new IN_VALID with A=12'h555 is ignored.
REQ-035 RST pulsed at cycle 2 of an ADD for A=12'hABC, B=12'h123 -> no OUT_VALID, SUM=0, and the next operation A=12'h100, B=12'h0FF gives SUM=12'h1FF, COUT=0.
REQ-036 Random back-to-back run of 1000 operands with random OUT_READY -> every {COUT,SUM} matches A+B+CIN.
